// File: rtl/num_ascii_streamer.sv
// Binary-to-ASCII line printer: decimal (unsigned/signed) or uppercase hex with
// leading-zero suppression and a trailing newline, streamed over valid/ready.
module num_ascii_streamer #(
    parameter int WIDTH     = 32,
    parameter int DIGITS    = 10,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    input  logic             hex_mode,
    input  logic             start,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int BCD_W      = DIGITS * 4;
    localparam int HEX_DIGITS = (WIDTH + 3) / 4;
    localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W      = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] MAG_ONE  = WIDTH'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CONVERT,
        S_SCAN,
        S_SIGN,
        S_EMIT,
        S_TERM,
        S_FIN
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               tx_valid_q;
    logic [7:0]         tx_data_q;
    logic               done_q;

    logic [WIDTH-1:0]   val_q;
    logic               signed_q;
    logic               hex_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;

    logic               neg_d;
    logic [WIDTH-1:0]   mag_d;
    logic [BCD_W-1:0]   dabble_d;
    logic [IDX_W-1:0]   msd_d;
    logic [IDX_W-1:0]   idx_nxt_d;
    logic [7:0]         msd_chr_d;
    logic [7:0]         cur_chr_d;
    logic [7:0]         nxt_chr_d;

    // One double-dabble step: add 3 to every digit >= 5, then shift in bit_in.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b,
                                                input logic bit_in);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    // Index of the most-significant nonzero digit; 0 when every digit is zero.
    function automatic logic [IDX_W-1:0] msd_idx(input logic [BCD_W-1:0] b,
                                                 input logic hex);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((!hex || i < HEX_DIGITS) && b[4*i +: 4] != 4'd0) r = i[IDX_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b,
                                            input logic [IDX_W-1:0] i);
        return b[4*int'(i) +: 4];
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    always_comb begin
        neg_d     = signed_q & ~hex_q & val_q[WIDTH-1];
        mag_d     = neg_d ? (~val_q + MAG_ONE) : val_q;
        dabble_d  = dabble(bcd_q, mag_q[WIDTH-1]);
        msd_d     = msd_idx(bcd_q, hex_q);
        idx_nxt_d = idx_q - IDX_ONE;
        msd_chr_d = to_ascii(digit_at(bcd_q, msd_d));
        cur_chr_d = to_ascii(digit_at(bcd_q, idx_q));
        nxt_chr_d = to_ascii(digit_at(bcd_q, idx_nxt_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP:    state_q <= hex_q ? S_SCAN : S_CONVERT;
                S_CONVERT: if (cnt_q == CNT_LAST) state_q <= S_SCAN;
                S_SCAN: begin
                    tx_valid_q <= 1'b1;
                    if (neg_q) begin
                        tx_data_q <= 8'h2D;
                        state_q   <= S_SIGN;
                    end else begin
                        tx_data_q <= msd_chr_d;
                        state_q   <= S_EMIT;
                    end
                end
                S_SIGN: begin
                    if (tx_ready) begin
                        tx_data_q <= cur_chr_d;
                        state_q   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tx_ready) begin
                        if (idx_q == '0) begin
                            tx_data_q <= 8'h0A;
                            state_q   <= S_TERM;
                        end else begin
                            tx_data_q <= nxt_chr_d;
                        end
                    end
                end
                S_TERM: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM reinitialises them on every line.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    val_q    <= value;
                    signed_q <= is_signed && SIGNED_EN;
                    hex_q    <= hex_mode;
                end
            end
            S_PREP: begin
                neg_q <= neg_d;
                mag_q <= mag_d;
                cnt_q <= '0;
                bcd_q <= hex_q ? BCD_W'(mag_d) : '0;
            end
            S_CONVERT: begin
                bcd_q <= dabble_d;
                mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                cnt_q <= cnt_q + CNT_ONE;
            end
            S_SCAN: idx_q <= msd_d;
            S_EMIT: if (tx_ready && idx_q != '0) idx_q <= idx_nxt_d;
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_num_ascii_streamer.sv
// Bench for num_ascii_streamer: table of lines with hand-computed text and
// latency, plus sequences for backpressure, ignored restart, SIGNED_EN=0 and reset.
module tb_num_ascii_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        is_signed;
    logic        hex_mode;
    logic        start0, start1;
    logic        tx_ready;
    logic        busy0, busy1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_valid0, tx_valid1;
    logic        done0, done1;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    num_ascii_streamer #(.WIDTH(32), .DIGITS(10), .SIGNED_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .value(value), .is_signed(is_signed),
        .hex_mode(hex_mode), .start(start0), .busy(busy0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready), .done(done0)
    );

    num_ascii_streamer #(.WIDTH(32), .DIGITS(10), .SIGNED_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .value(value), .is_signed(is_signed),
        .hex_mode(hex_mode), .start(start1), .busy(busy1), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready), .done(done1)
    );

    typedef struct {
        logic [31:0] v;
        logic        s;
        logic        h;
        logic [95:0] exp;
        int          len;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_start(input int inst, input logic b);
        if (inst == 0) start0 = b;
        else start1 = b;
    endtask

    // Runs one full line on the chosen instance and checks text, timing and handshake.
    task automatic run_line(input string nm, input int inst, input logic [31:0] v,
                            input logic s, input logic h, input logic [95:0] exp,
                            input int len, input int lat, input int rmode,
                            input bit restart);
        logic [95:0] got;
        logic [7:0]  td, pd;
        logic        tv, dn, bz, rdy, stl, fin, hold_bad, early_done, idle_bad;
        logic [5:0]  pat;
        int          n, n0, first, last, k;
        got = '0; n = 0; first = -1; last = -1; k = 0;
        pd = 8'h00; stl = 1'b0; fin = 1'b0; hold_bad = 1'b0;
        early_done = 1'b0; idle_bad = 1'b0;
        pat = 6'b101001;
        tx_ready = 1'b1;
        value = v; is_signed = s; hex_mode = h;
        set_start(inst, 1'b1);
        n0 = cyc;
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        value = ~v; is_signed = ~s; hex_mode = ~h;
        bz = (inst == 0) ? busy0 : busy1;
        chk({nm, " busy after accept"}, 96'(bz), 96'(1));
        for (int t = 0; t < 300 && !fin; t++) begin
            tv = (inst == 0) ? tx_valid0 : tx_valid1;
            td = (inst == 0) ? tx_data0 : tx_data1;
            dn = (inst == 0) ? done0 : done1;
            if (stl && (!tv || td != pd)) hold_bad = 1'b1;
            if (dn) early_done = 1'b1;
            if (tv && first < 0) first = cyc - n0;
            if (restart && t == 3) set_start(inst, 1'b1);
            if (restart && t == 5) set_start(inst, 1'b0);
            rdy = (rmode == 0) ? 1'b1 : pat[k % 6];
            if (tv) k++;
            tx_ready = rdy;
            if (tv && rdy) begin
                got = {got[87:0], td};
                n++;
                last = cyc - n0;
                if (td == 8'h0A) fin = 1'b1;
            end
            stl = tv && !rdy;
            pd = td;
            @(posedge clk); #1;
        end
        set_start(inst, 1'b0);
        tx_ready = 1'b1;
        chk({nm, " line finished"}, 96'(fin), 96'(1));
        dn = (inst == 0) ? done0 : done1;
        tv = (inst == 0) ? tx_valid0 : tx_valid1;
        bz = (inst == 0) ? busy0 : busy1;
        chk({nm, " done pulse"}, 96'(dn), 96'(1));
        chk({nm, " busy with done"}, 96'(bz), 96'(1));
        chk({nm, " valid low after newline"}, 96'(tv), 96'(0));
        @(posedge clk); #1;
        dn = (inst == 0) ? done0 : done1;
        bz = (inst == 0) ? busy0 : busy1;
        chk({nm, " done one cycle"}, 96'(dn), 96'(0));
        chk({nm, " busy dropped"}, 96'(bz), 96'(0));
        for (int t = 0; t < 4; t++) begin
            if ((inst == 0 ? (tx_valid0 | busy0) : (tx_valid1 | busy1))) idle_bad = 1'b1;
            @(posedge clk); #1;
        end
        chk({nm, " stays idle"}, 96'(idle_bad), 96'(0));
        chk({nm, " text"}, got, exp);
        chk({nm, " char count"}, 96'(n), 96'(len));
        chk({nm, " first valid latency"}, 96'(first), 96'(lat));
        chk({nm, " held during stall"}, 96'(hold_bad), 96'(0));
        chk({nm, " no early done"}, 96'(early_done), 96'(0));
        if (rmode == 0) chk({nm, " back-to-back"}, 96'(last - first), 96'(len - 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int   n;
        vecs[0]  = '{32'd1234,       1'b0, 1'b0, 96'("1234\n"),         5, 35};
        vecs[1]  = '{32'd0,          1'b0, 1'b0, 96'("0\n"),            2, 35};
        vecs[2]  = '{32'd0,          1'b0, 1'b1, 96'("0\n"),            2, 3};
        vecs[3]  = '{32'hFFFFFFFF,   1'b0, 1'b0, 96'("4294967295\n"),  11, 35};
        vecs[4]  = '{32'hFFFFFFFF,   1'b1, 1'b0, 96'("-1\n"),           3, 35};
        vecs[5]  = '{32'h80000000,   1'b1, 1'b0, 96'("-2147483648\n"), 12, 35};
        vecs[6]  = '{32'h00ABC012,   1'b1, 1'b1, 96'("ABC012\n"),       7, 3};
        vecs[7]  = '{32'h80000000,   1'b0, 1'b0, 96'("2147483648\n"),  11, 35};
        vecs[8]  = '{32'h7FFFFFFF,   1'b1, 1'b0, 96'("2147483647\n"),  11, 35};
        vecs[9]  = '{32'hDEADBEEF,   1'b0, 1'b1, 96'("DEADBEEF\n"),     9, 3};
        vecs[10] = '{32'hFFFFFFF6,   1'b1, 1'b0, 96'("-10\n"),          4, 35};

        rst = 1'b1; value = '0; is_signed = 1'b0; hex_mode = 1'b0;
        start0 = 1'b0; start1 = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset busy", 96'(busy0), 96'(0));
        chk("reset tx_valid", 96'(tx_valid0), 96'(0));
        chk("reset tx_data", 96'(tx_data0), 96'(0));
        chk("reset done", 96'(done0), 96'(0));
        chk("reset tx_valid unsigned inst", 96'(tx_valid1), 96'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_line($sformatf("vec%0d", i), 0, vecs[i].v, vecs[i].s, vecs[i].h,
                     vecs[i].exp, vecs[i].len, vecs[i].lat, 0, 1'b0);
        end

        run_line("backpressure", 0, 32'd907, 1'b0, 1'b0, 96'("907\n"), 4, 35, 1, 1'b0);
        run_line("restart ignored", 0, 32'd1234, 1'b0, 1'b0, 96'("1234\n"), 5, 35, 0, 1'b1);
        run_line("signed disabled", 1, 32'h80000000, 1'b1, 1'b0, 96'("2147483648\n"), 11, 35, 0, 1'b0);

        // Reset in the middle of "1234\n" after two characters have gone out.
        value = 32'd1234; is_signed = 1'b0; hex_mode = 1'b0; tx_ready = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        for (int t = 0; t < 100 && n < 2; t++) begin
            if (tx_valid0 && tx_ready) n++;
            @(posedge clk); #1;
        end
        chk("abort two chars sent", 96'(n), 96'(2));
        chk("abort third char", 96'(tx_data0), 96'(8'h33));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort tx_valid", 96'(tx_valid0), 96'(0));
        chk("abort busy", 96'(busy0), 96'(0));
        chk("abort tx_data", 96'(tx_data0), 96'(0));
        chk("abort done", 96'(done0), 96'(0));
        bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done0 || tx_valid0) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort silent", 96'(bad), 96'(0));
        run_line("after abort", 0, 32'd1234, 1'b0, 1'b0, 96'("1234\n"), 5, 35, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/num_ascii_streamer.md
Name: num_ascii_streamer

Overview:
- Converts a WIDTH-bit binary value to an ASCII text line: decimal (unsigned or two's-complement signed) or uppercase hex.
- Leading-zero suppression; the line is terminated by "\n".
- Streams one character per transfer over a valid/ready byte interface toward the serial TX path.
- Generalised successor to the fixed 32-bit, address-indexed digit printer: parametrised width, sign and hex modes, and flow control.

Parameters:
- WIDTH, 32: input value width; must be ≥4.
- DIGITS, 10: BCD digit count. Must satisfy DIGITS ≥ decimal digits of 2^WIDTH−1 and DIGITS*4 ≥ WIDTH.
- SIGNED_EN, 1: when 0, is_signed is ignored and treated as 0; sign logic may be removed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  WIDTH  number to print; sampled only on start accept.
- is_signed  in  1  decimal mode only: interpret value as two's complement; sampled on accept.
- hex_mode  in  1  1 = hex output, 0 = decimal output; sampled on accept.
- start  in  1  request; accepted when start=1 and busy=0.
- busy  out  1  high from the cycle after accept through the cycle done is asserted.
- tx_data  out  8  ASCII character.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts tx_data this cycle.
- done  out  1  one-cycle pulse after the "\n" transfer.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, busy=0, tx_valid=0, tx_data=8'h00, done=0.
  - Reset has priority over every other event, including mid-conversion or mid-stream.
  - An aborted line emits nothing further and produces no done pulse.
- States: IDLE → PREP → CONVERT (decimal only) → SCAN → [SIGN] → EMIT → TERM → FIN → IDLE.
- IDLE: on accept at cycle N, capture value, is_signed, hex_mode. busy=1 from N+1. start while busy=1 is ignored and not queued.
- PREP (1 cycle):
  - neg = is_signed & SIGNED_EN & value[WIDTH-1] (forced 0 in hex mode).
  - mag = neg ? (~value+1) : value, in WIDTH bits. The most-negative value yields 2^(WIDTH-1) correctly as unsigned.
- CONVERT: shift-add-3 (double dabble), exactly WIDTH cycles, one bit per cycle, MSB first, into a DIGITS*4-bit BCD register.
- Hex mode skips CONVERT: mag is zero-extended into the digit register as nibbles.
  - Digit count is DIGITS in decimal mode and ceil(WIDTH/4) in hex mode.
- SCAN (1 cycle): find the index of the most-significant nonzero digit. If all digits are zero, emit the single digit "0".
- SIGN: present "-" only if neg=1.
- EMIT: present digits from the most-significant nonzero digit down to digit 0.
  - Decimal digit d → 8'h30+d.
  - Hex digit ≥10 → 8'h41+(d−10), i.e. uppercase A–F.
- TERM: present 8'h0A.
- FIN: done=1 for exactly one cycle, busy drops to 0 the next cycle, return to IDLE.
  - A new start may be accepted in the first cycle busy=0.
- First tx_valid cycle:
  - decimal: N+WIDTH+3;
  - hex: N+3.
- Handshake:
  - A transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - After a transfer, the next character is valid on the following cycle; a continuous tx_ready=1 gives one character per clock.
  - tx_valid never deasserts without a transfer, except on reset.
- tx_ready is ignored when tx_valid=0. tx_data is don't-care when tx_valid=0, but holds its last value.
- Captured inputs are never re-read mid-line; changes to value or modes while busy have no effect.

Test Plan:
- WIDTH=32, value=1234, unsigned decimal, tx_ready=1 → "1234\n"; first tx_valid at N+35; 5 consecutive transfers; done at the cycle after the "\n" transfer.
- value=0, both decimal and hex → "0\n" each; value=32'd4294967295 unsigned → "4294967295\n" (10 digits, no suppression).
- value=32'hFFFFFFFF signed → "-1\n"; value=32'h80000000 signed → "-2147483648\n"; the same with SIGNED_EN=0 → "2147483648\n".
- hex_mode=1, value=32'h00ABC012, is_signed=1 → "ABC012\n" with no sign; first tx_valid at N+3.
- Backpressure: value=907, tx_ready pattern 1,0,0,1,0,1… → tx_data held constant across stalls; the exact sequence "907\n" is received; no duplicated or dropped characters.
- Second start while busy → ignored, exactly one line emitted.
- rst asserted after 2 characters of "1234\n" → tx_valid=0 the next cycle, no done; a fresh start then yields the full line.
